// File: rtl/execute_stage_if.sv
// Decode->execute operands and execute->memory/writeback results for execute_stage.
// slave: the execute stage; master: upstream driver and downstream consumer.
interface execute_stage_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  enable_execute;
   logic [31:0]           pc;
   logic [5:0]            opcode;
   logic [5:0]            func;
   logic [4:0]            rt;
   logic [4:0]            rd;
   logic [4:0]            sa;
   logic [25:0]           imm;
   logic [DATA_WIDTH-1:0] rs_val;
   logic [DATA_WIDTH-1:0] rt_val;
   logic                  valid_out;
   logic [DATA_WIDTH-1:0] result;
   logic [4:0]            dest_reg;
   logic                  reg_write;
   logic                  is_load;
   logic                  is_store;
   logic [DATA_WIDTH-1:0] store_data;
   logic                  branch_taken;
   logic [31:0]           branch_target;
   logic                  stall;

   modport master (
      output enable_execute, pc, opcode, func, rt, rd, sa, imm, rs_val, rt_val,
      input  valid_out, result, dest_reg, reg_write, is_load, is_store, store_data,
             branch_taken, branch_target, stall
   );

   modport slave (
      input  enable_execute, pc, opcode, func, rt, rd, sa, imm, rs_val, rt_val,
      output valid_out, result, dest_reg, reg_write, is_load, is_store, store_data,
             branch_taken, branch_target, stall
   );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: results registered one edge after accept; HI/LO + iterative MDU (33-cycle stall)
// exist only when EXECUTE_MDU_EN is defined, otherwise MULT/DIV are NOPs and MFHI/MFLO read 0.
module execute_stage #(
   parameter int DATA_WIDTH = 32
) (
   input logic            clock,
   input logic            reset_n,
   execute_stage_if.slave bus
);
   localparam int DW = DATA_WIDTH;

   logic          stall, accept;
   logic [DW-1:0] hi_val, lo_val;
   logic [DW-1:0] rs, rtv, sext16, zext16;
   logic [31:0]   pc4;

   logic          valid_d, wr_d, ld_d, st_d, tk_d;
   logic [DW-1:0] res_d, sdat_d;
   logic [4:0]    dest_d;
   logic [31:0]   tgt_d;
   logic          valid_q, wr_q, ld_q, st_q, tk_q;
   logic [DW-1:0] res_q, sdat_q;
   logic [4:0]    dest_q;
   logic [31:0]   tgt_q;

   assign rs     = bus.rs_val;
   assign rtv    = bus.rt_val;
   assign sext16 = {{(DW-16){bus.imm[15]}}, bus.imm[15:0]};
   assign zext16 = {{(DW-16){1'b0}}, bus.imm[15:0]};
   assign pc4    = bus.pc + 32'd4;
   assign accept = bus.enable_execute && !stall;
   assign valid_d = accept;

   always_comb begin
      res_d  = '0;
      dest_d = '0;
      wr_d   = 1'b0;
      ld_d   = 1'b0;
      st_d   = 1'b0;
      sdat_d = '0;
      tk_d   = 1'b0;
      tgt_d  = '0;
      if (accept) begin
         case (bus.opcode)
            6'h00: begin
               dest_d = bus.rd;
               wr_d   = 1'b1;
               case (bus.func)
                  6'h20, 6'h21: res_d = rs + rtv;
                  6'h23:        res_d = rs - rtv;
                  6'h24:        res_d = rs & rtv;
                  6'h25:        res_d = rs | rtv;
                  6'h26:        res_d = rs ^ rtv;
                  6'h27:        res_d = ~(rs | rtv);
                  6'h2A:        res_d = {{(DW-1){1'b0}}, $signed(rs) < $signed(rtv)};
                  6'h2B:        res_d = {{(DW-1){1'b0}}, rs < rtv};
                  6'h00:        res_d = rtv << bus.sa;
                  6'h02:        res_d = rtv >> bus.sa;
                  6'h03:        res_d = $signed(rtv) >>> bus.sa;
                  6'h10:        res_d = hi_val;
                  6'h12:        res_d = lo_val;
                  6'h08: begin
                     wr_d   = 1'b0;
                     dest_d = '0;
                     tk_d   = 1'b1;
                     tgt_d  = 32'(rs);
                  end
                  // MULT/DIV family and unknown funcs write nothing
                  default: begin
                     wr_d   = 1'b0;
                     dest_d = '0;
                  end
               endcase
            end
            6'h09: begin res_d = rs + sext16; dest_d = bus.rt; wr_d = 1'b1; end
            6'h0A: begin
               res_d  = {{(DW-1){1'b0}}, $signed(rs) < $signed(sext16)};
               dest_d = bus.rt;
               wr_d   = 1'b1;
            end
            6'h0C: begin res_d = rs & zext16; dest_d = bus.rt; wr_d = 1'b1; end
            6'h0D: begin res_d = rs | zext16; dest_d = bus.rt; wr_d = 1'b1; end
            6'h0F: begin res_d = DW'({bus.imm[15:0], 16'h0000}); dest_d = bus.rt; wr_d = 1'b1; end
            6'h23: begin res_d = rs + sext16; dest_d = bus.rt; wr_d = 1'b1; ld_d = 1'b1; end
            6'h2B: begin res_d = rs + sext16; st_d = 1'b1; sdat_d = rtv; end
            6'h04, 6'h05: begin
               tgt_d = pc4 + {{14{bus.imm[15]}}, bus.imm[15:0], 2'b00};
               tk_d  = (rs == rtv) ^ bus.opcode[0];
            end
            6'h02: begin tgt_d = {pc4[31:28], bus.imm, 2'b00}; tk_d = 1'b1; end
            6'h03: begin
               tgt_d  = {pc4[31:28], bus.imm, 2'b00};
               tk_d   = 1'b1;
               res_d  = DW'(bus.pc + 32'd8);
               dest_d = 5'd31;
               wr_d   = 1'b1;
            end
            default: ;
         endcase
         if (dest_d == 5'd0) wr_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0; res_q <= '0; dest_q <= '0; wr_q <= 1'b0; ld_q <= 1'b0;
         st_q <= 1'b0; sdat_q <= '0; tk_q <= 1'b0; tgt_q <= '0;
      end else begin
         valid_q <= valid_d; res_q <= res_d; dest_q <= dest_d; wr_q <= wr_d; ld_q <= ld_d;
         st_q <= st_d; sdat_q <= sdat_d; tk_q <= tk_d; tgt_q <= tgt_d;
      end
   end

   assign bus.valid_out     = valid_q;
   assign bus.result        = res_q;
   assign bus.dest_reg      = dest_q;
   assign bus.reg_write     = wr_q;
   assign bus.is_load       = ld_q;
   assign bus.is_store      = st_q;
   assign bus.store_data    = sdat_q;
   assign bus.branch_taken  = tk_q;
   assign bus.branch_target = tgt_q;
   assign bus.stall         = stall;

`ifdef EXECUTE_MDU_EN
   localparam int CW = $clog2(DW);
   typedef enum logic [1:0] {IDLE, BUSY, FIX} mdu_state_t;

   mdu_state_t      state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   acc_hi_q, acc_lo_q, opnd_q, hi_q, lo_q;
   logic            is_div_q, neg_q, neg_rem_q, dz_q;
   logic            mdu_start, sgn, rs_neg, rt_neg, rem_ge;
   logic [DW-1:0]   rs_mag, rt_mag;
   logic [DW:0]     add_sum, rem_sh, rem_sub;
   logic [2*DW-1:0] prod;

   // func 0x18..0x1B: bit0 selects unsigned, bit1 selects divide
   assign mdu_start = accept && (bus.opcode == 6'h00) && (bus.func[5:2] == 4'b0110);
   assign sgn       = ~bus.func[0];
   assign rs_neg    = sgn & rs[DW-1];
   assign rt_neg    = sgn & rtv[DW-1];
   assign rs_mag    = rs_neg ? -rs : rs;
   assign rt_mag    = rt_neg ? -rtv : rtv;
   assign add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign rem_sh    = {acc_hi_q, acc_lo_q[DW-1]};
   assign rem_ge    = rem_sh >= {1'b0, opnd_q};
   assign rem_sub   = rem_sh - {1'b0, opnd_q};
   assign prod      = {acc_hi_q, acc_lo_q};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE; cnt_q <= '0; acc_hi_q <= '0; acc_lo_q <= '0; opnd_q <= '0;
         is_div_q <= 1'b0; neg_q <= 1'b0; neg_rem_q <= 1'b0; dz_q <= 1'b0;
         hi_q <= '0; lo_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (mdu_start) begin
               acc_hi_q  <= '0;
               acc_lo_q  <= rs_mag;
               opnd_q    <= rt_mag;
               is_div_q  <= bus.func[1];
               neg_q     <= rs_neg ^ rt_neg;
               neg_rem_q <= rs_neg;
               dz_q      <= (rtv == '0);
               cnt_q     <= '0;
               state_q   <= BUSY;
            end
            BUSY: begin
               if (is_div_q) begin
                  acc_hi_q <= rem_ge ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
                  acc_lo_q <= {acc_lo_q[DW-2:0], rem_ge};
               end else begin
                  acc_hi_q <= add_sum[DW:1];
                  acc_lo_q <= {add_sum[0], acc_lo_q[DW-1:1]};
               end
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(DW-1)) state_q <= FIX;
            end
            FIX: begin
               // a zero divisor leaves the dividend magnitude in the remainder already
               if (is_div_q) begin
                  lo_q <= dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
                  hi_q <= neg_rem_q ? -acc_hi_q : acc_hi_q;
               end else begin
                  {hi_q, lo_q} <= neg_q ? -prod : prod;
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall  = (state_q != IDLE);
   assign hi_val = hi_q;
   assign lo_val = lo_q;
`else
   assign stall  = 1'b0;
   assign hi_val = '0;
   assign lo_val = '0;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, randomized ALU/branch traffic
// against an arithmetic reference model, and hand-written MDU / reset sequences.
module tb_execute_stage;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   execute_stage_if bus ();
   execute_stage dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      logic        rw, ld, st, tk;
      logic [31:0] tgt;
      logic [31:0] sdat;
   } exp_t;

   typedef struct {
      string       name;
      logic [5:0]  op, fn;
      logic [4:0]  rt, rd, sa;
      logic [25:0] imm;
      logic [31:0] pc, rs, rtv;
      exp_t        e;
   } vec_t;

   vec_t vecs[19];
   logic [5:0] rfns [15] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                             6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h08};
   logic [5:0] iops [11] = '{6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B,
                             6'h04, 6'h05, 6'h02, 6'h03};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic exp_t mke(input logic [31:0] res, input logic [4:0] dest,
                                input logic rw, ld, st, tk, input logic [31:0] tgt, sdat);
      exp_t e;
      e.res = res; e.dest = dest; e.rw = rw; e.ld = ld; e.st = st; e.tk = tk;
      e.tgt = tgt; e.sdat = sdat;
      return e;
   endfunction

   function automatic vec_t mkv(input string nm, input logic [5:0] op, fn,
                                input logic [4:0] rt, rd, sa, input logic [25:0] imm,
                                input logic [31:0] pc, rs, rtv, input exp_t e);
      vec_t v;
      v.name = nm; v.op = op; v.fn = fn; v.rt = rt; v.rd = rd; v.sa = sa; v.imm = imm;
      v.pc = pc; v.rs = rs; v.rtv = rtv; v.e = e;
      return v;
   endfunction

   // Reference model: instruction semantics as plain 32-bit arithmetic.
   function automatic exp_t model(input logic [5:0] op, fn, input logic [4:0] rt, rd, sa,
                                  input logic [25:0] imm, input logic [31:0] pc, rs, rtv);
      exp_t e = mke('0, '0, 0, 0, 0, 0, '0, '0);
      int s16 = int'($signed(imm[15:0]));
      logic [31:0] se = s16;
      logic [31:0] zi = {16'h0, imm[15:0]};
      logic [31:0] hi_mask;
      if (op == 6'h00) begin
         e.dest = rd; e.rw = 1;
         case (fn)
            6'h20, 6'h21: e.res = rs + rtv;
            6'h23: e.res = rs - rtv;
            6'h24: e.res = rs & rtv;
            6'h25: e.res = rs | rtv;
            6'h26: e.res = rs ^ rtv;
            6'h27: e.res = ~(rs | rtv);
            6'h2A: e.res = (int'(rs) < int'(rtv)) ? 32'd1 : 32'd0;
            6'h2B: e.res = (rs < rtv) ? 32'd1 : 32'd0;
            6'h00: e.res = rtv * (32'd1 << sa);
            6'h02: e.res = rtv / (32'd1 << sa);
            6'h03: begin
               hi_mask = ~(32'hFFFF_FFFF >> sa);
               e.res = (rtv >> sa) | (rtv[31] ? hi_mask : 32'd0);
            end
            6'h10: e.res = hi_m;
            6'h12: e.res = lo_m;
            6'h08: begin e.rw = 0; e.tk = 1; e.tgt = rs; end
            default: e.rw = 0;
         endcase
      end else begin
         e.dest = rt;
         case (op)
            6'h09: begin e.rw = 1; e.res = rs + se; end
            6'h0A: begin e.rw = 1; e.res = (int'(rs) < s16) ? 32'd1 : 32'd0; end
            6'h0C: begin e.rw = 1; e.res = rs & zi; end
            6'h0D: begin e.rw = 1; e.res = rs | zi; end
            6'h0F: begin e.rw = 1; e.res = zi * 32'h10000; end
            6'h23: begin e.rw = 1; e.ld = 1; e.res = rs + se; end
            6'h2B: begin e.st = 1; e.res = rs + se; e.sdat = rtv; end
            6'h04: begin e.tk = (rs == rtv); e.tgt = pc + 4 + se * 4; end
            6'h05: begin e.tk = (rs != rtv); e.tgt = pc + 4 + se * 4; end
            6'h02: begin e.tk = 1; e.tgt = ((pc + 4) & 32'hF000_0000) | (32'(imm) * 4); end
            6'h03: begin
               e.tk = 1; e.tgt = ((pc + 4) & 32'hF000_0000) | (32'(imm) * 4);
               e.rw = 1; e.dest = 5'd31; e.res = pc + 8;
            end
            default: ;
         endcase
      end
      if (e.dest == 0) e.rw = 0;
      return e;
   endfunction

   task automatic mdu_model(input logic [5:0] fn, input logic [31:0] a, b);
`ifdef EXECUTE_MDU_EN
      longint sa64, sb64, q, r;
      logic [63:0] p;
      case (fn)
         6'h18: begin p = longint'(int'(a)) * longint'(int'(b)); hi_m = p[63:32]; lo_m = p[31:0]; end
         6'h19: begin p = {32'h0, a} * {32'h0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
         default: begin
            if (b == 0) begin
               lo_m = 32'hFFFF_FFFF; hi_m = a;
            end else if (fn == 6'h1A) begin
               sa64 = longint'(int'(a)); sb64 = longint'(int'(b));
               q = sa64 / sb64; r = sa64 % sb64;
               lo_m = q[31:0]; hi_m = r[31:0];
            end else begin
               lo_m = a / b; hi_m = a % b;
            end
         end
      endcase
`else
      hi_m = '0; lo_m = '0;
      if (fn == 6'h00 && a == b) hi_m = '0;
`endif
   endtask

   task automatic drive(input logic [5:0] op, fn, input logic [4:0] rt, rd, sa,
                        input logic [25:0] imm, input logic [31:0] pc, rs, rtv);
      @(negedge clock);
      bus.opcode = op; bus.func = fn; bus.rt = rt; bus.rd = rd; bus.sa = sa; bus.imm = imm;
      bus.pc = pc; bus.rs_val = rs; bus.rt_val = rtv; bus.enable_execute = 1'b1;
      @(posedge clock);
      #1 bus.enable_execute = 1'b0;
   endtask

   task automatic check_exp(input string nm, input exp_t e);
      chk({nm, ".valid"}, 32'(bus.valid_out), 1);
      chk({nm, ".reg_write"}, 32'(bus.reg_write), 32'(e.rw));
      chk({nm, ".is_load"}, 32'(bus.is_load), 32'(e.ld));
      chk({nm, ".is_store"}, 32'(bus.is_store), 32'(e.st));
      chk({nm, ".taken"}, 32'(bus.branch_taken), 32'(e.tk));
      if (e.rw) chk({nm, ".dest"}, 32'(bus.dest_reg), 32'(e.dest));
      if (e.rw || e.ld || e.st) chk({nm, ".result"}, bus.result, e.res);
      if (e.st) chk({nm, ".store_data"}, bus.store_data, e.sdat);
      if (e.tk) chk({nm, ".target"}, bus.branch_target, e.tgt);
   endtask

   task automatic check_idle(input string nm);
      chk({nm, ".valid"}, 32'(bus.valid_out), 0);
      chk({nm, ".reg_write"}, 32'(bus.reg_write), 0);
      chk({nm, ".is_load"}, 32'(bus.is_load), 0);
      chk({nm, ".is_store"}, 32'(bus.is_store), 0);
      chk({nm, ".taken"}, 32'(bus.branch_taken), 0);
   endtask

   task automatic check_all_zero(input string nm);
      check_idle(nm);
      chk({nm, ".result"}, bus.result, 0);
      chk({nm, ".dest"}, 32'(bus.dest_reg), 0);
      chk({nm, ".store_data"}, bus.store_data, 0);
      chk({nm, ".target"}, bus.branch_target, 0);
      chk({nm, ".stall"}, 32'(bus.stall), 0);
   endtask

   task automatic run_mdu(input string nm, input logic [5:0] fn, input logic [31:0] a, b,
                          input bit hold);
      int n = 0;
      drive(6'h00, fn, 5'd0, 5'd0, 5'd0, 26'd0, 32'd0, a, b);
      chk({nm, ".valid"}, 32'(bus.valid_out), 1);
      chk({nm, ".reg_write"}, 32'(bus.reg_write), 0);
      if (hold) begin
         bus.enable_execute = 1'b1; bus.func = 6'h21; bus.rd = 5'd5;
      end
      while (bus.stall && n < 60) begin
         n++;
         @(posedge clock);
         #1;
         if (hold) chk({nm, ".ignored_while_stalled"}, 32'(bus.valid_out), 0);
      end
      bus.enable_execute = 1'b0;
`ifdef EXECUTE_MDU_EN
      chk({nm, ".stall_cycles"}, n, 33);
`else
      chk({nm, ".stall_cycles"}, n, 0);
`endif
      mdu_model(fn, a, b);
   endtask

   task automatic read_hilo(input string nm, input logic [31:0] exp_lo, exp_hi);
      drive(6'h00, 6'h12, 5'd0, 5'd2, 5'd0, 26'd0, 32'd0, 32'd0, 32'd0);
      chk({nm, ".lo"}, bus.result, exp_lo);
      drive(6'h00, 6'h10, 5'd0, 5'd2, 5'd0, 26'd0, 32'd0, 32'd0, 32'd0);
      chk({nm, ".hi"}, bus.result, exp_hi);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [5:0] op, fn;
      logic [31:0] a, b;

      vecs[0]  = mkv("addu_ovf", 6'h00, 6'h21, 5'd0, 5'd3, 5'd0, 26'd0, 32'd0, 32'h7FFF_FFFF, 32'd1, mke(32'h8000_0000, 5'd3, 1, 0, 0, 0, 0, 0));
      vecs[1]  = mkv("slt", 6'h00, 6'h2A, 5'd0, 5'd4, 5'd0, 26'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, mke(32'd1, 5'd4, 1, 0, 0, 0, 0, 0));
      vecs[2]  = mkv("sltu", 6'h00, 6'h2B, 5'd0, 5'd4, 5'd0, 26'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, mke(32'd0, 5'd4, 1, 0, 0, 0, 0, 0));
      vecs[3]  = mkv("beq_eq", 6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000FFFF, 32'h8002_0000, 32'h1234, 32'h1234, mke(0, 0, 0, 0, 0, 1, 32'h8002_0000, 0));
      vecs[4]  = mkv("beq_ne", 6'h04, 6'h00, 5'd0, 5'd0, 5'd0, 26'h000FFFF, 32'h8002_0000, 32'd1, 32'd2, mke(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[5]  = mkv("bne_ne", 6'h05, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0000004, 32'h0000_1000, 32'd1, 32'd2, mke(0, 0, 0, 0, 0, 1, 32'h0000_1014, 0));
      vecs[6]  = mkv("lui", 6'h0F, 6'h00, 5'd7, 5'd0, 5'd0, 26'h000ABCD, 32'd0, 32'd0, 32'd0, mke(32'hABCD_0000, 5'd7, 1, 0, 0, 0, 0, 0));
      vecs[7]  = mkv("lw", 6'h23, 6'h00, 5'd8, 5'd0, 5'd0, 26'h000FFFC, 32'd0, 32'h1000, 32'd0, mke(32'h0FFC, 5'd8, 1, 1, 0, 0, 0, 0));
      vecs[8]  = mkv("sw", 6'h2B, 6'h00, 5'd9, 5'd0, 5'd0, 26'h0000010, 32'd0, 32'h2000, 32'hDEAD_BEEF, mke(32'h2010, 0, 0, 0, 1, 0, 0, 32'hDEAD_BEEF));
      vecs[9]  = mkv("jal", 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 26'h0123456, 32'h4000_0010, 32'd0, 32'd0, mke(32'h4000_0018, 5'd31, 1, 0, 0, 1, 32'h4048_D158, 0));
      vecs[10] = mkv("jr", 6'h00, 6'h08, 5'd0, 5'd0, 5'd0, 26'd0, 32'd0, 32'h1234_5678, 32'd0, mke(0, 0, 0, 0, 0, 1, 32'h1234_5678, 0));
      vecs[11] = mkv("sra", 6'h00, 6'h03, 5'd0, 5'd9, 5'd4, 26'd0, 32'd0, 32'd0, 32'h8000_0000, mke(32'hF800_0000, 5'd9, 1, 0, 0, 0, 0, 0));
      vecs[12] = mkv("addu_r0", 6'h00, 6'h21, 5'd0, 5'd0, 5'd0, 26'd0, 32'd0, 32'd5, 32'd6, mke(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[13] = mkv("nop", 6'h3F, 6'h00, 5'd3, 5'd3, 5'd0, 26'h0000123, 32'd0, 32'd5, 32'd6, mke(0, 0, 0, 0, 0, 0, 0, 0));
      vecs[14] = mkv("andi", 6'h0C, 6'h00, 5'd10, 5'd0, 5'd0, 26'h0008F0F, 32'd0, 32'hFFFF_1234, 32'd0, mke(32'h0204, 5'd10, 1, 0, 0, 0, 0, 0));
      vecs[15] = mkv("addiu", 6'h09, 6'h00, 5'd11, 5'd0, 5'd0, 26'h000FFFE, 32'd0, 32'd5, 32'd0, mke(32'd3, 5'd11, 1, 0, 0, 0, 0, 0));
      vecs[16] = mkv("slti", 6'h0A, 6'h00, 5'd12, 5'd0, 5'd0, 26'h000FFFF, 32'd0, 32'hFFFF_FFFE, 32'd0, mke(32'd1, 5'd12, 1, 0, 0, 0, 0, 0));
      vecs[17] = mkv("j", 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 32'hF000_0000, 32'd0, 32'd0, mke(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0));
      vecs[18] = mkv("sltu_eq", 6'h00, 6'h2B, 5'd0, 5'd6, 5'd0, 26'd0, 32'd0, 32'd9, 32'd9, mke(32'd0, 5'd6, 1, 0, 0, 0, 0, 0));

      bus.enable_execute = 0; bus.pc = 0; bus.opcode = 0; bus.func = 0; bus.rt = 0;
      bus.rd = 0; bus.sa = 0; bus.imm = 0; bus.rs_val = 0; bus.rt_val = 0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 check_all_zero("reset");
      #1 reset_n = 1'b1;

      // directed table, plus the single-cycle valid_out pulse after the first entry
      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].rd, vecs[i].sa, vecs[i].imm,
               vecs[i].pc, vecs[i].rs, vecs[i].rtv);
         check_exp(vecs[i].name, vecs[i].e);
         if (vecs[i].name == "nop") chk("nop.result", bus.result, 0);
         if (i == 0) begin
            @(posedge clock);
            #1 check_idle("after_pulse");
         end
      end

      // randomized non-MDU traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 2) == 0) ? 6'h00 : iops[$urandom_range(0, 10)];
         fn = rfns[$urandom_range(0, 14)];
         if ($urandom_range(0, 19) == 0) op = 6'h3E;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         bus.rt = 5'($urandom); bus.rd = 5'($urandom); bus.sa = 5'($urandom);
         bus.imm = 26'($urandom); bus.pc = $urandom;
         e = model(op, fn, bus.rt, bus.rd, bus.sa, bus.imm, bus.pc, a, b);
         drive(op, fn, bus.rt, bus.rd, bus.sa, bus.imm, bus.pc, a, b);
         check_exp("rand", e);
      end

      // directed multiply/divide corner cases
      run_mdu("mult", 6'h18, 32'hFFFF_FFFD, 32'd5, 0);
`ifdef EXECUTE_MDU_EN
      read_hilo("mult", 32'hFFFF_FFF1, 32'hFFFF_FFFF);
`else
      read_hilo("mult", 32'h0, 32'h0);
`endif
      run_mdu("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 0);
`ifdef EXECUTE_MDU_EN
      read_hilo("div", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
`else
      read_hilo("div", 32'h0, 32'h0);
`endif
      run_mdu("divu_zero", 6'h1B, 32'd7, 32'd0, 1);
`ifdef EXECUTE_MDU_EN
      read_hilo("divu_zero", 32'hFFFF_FFFF, 32'd7);
`else
      read_hilo("divu_zero", 32'h0, 32'h0);
`endif

      // randomized multiply/divide against 64-bit arithmetic
      for (int i = 0; i < 16; i++) begin
         fn = 6'h18 + 6'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 5) == 0) b = 0;
         else if ($urandom_range(0, 1) == 1) b = $urandom;
         else b = $urandom_range(1, 20);
         run_mdu("rand_mdu", fn, a, b, 0);
         read_hilo("rand_mdu", lo_m, hi_m);
      end

      // make HI/LO non-zero, then reset part-way through a multiply
      run_mdu("pre_reset", 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      drive(6'h00, 6'h18, 5'd0, 5'd0, 5'd0, 26'd0, 32'd0, 32'd3, 32'd4);
      repeat (10) @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check_all_zero("mid_reset");
      hi_m = '0; lo_m = '0;
      @(posedge clock);
      #1 check_all_zero("held_reset");
      #1 reset_n = 1'b1;
      drive(6'h00, 6'h21, 5'd0, 5'd3, 5'd0, 26'd0, 32'd0, 32'd1, 32'd2);
      check_exp("post_reset_addu", mke(32'd3, 5'd3, 1, 0, 0, 0, 0, 0));
      read_hilo("post_reset", 32'd0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute stage sitting directly downstream of decode. Consumes decoded fields plus register-read operand values and produces a registered ALU result, destination register, write-enable, load/store flags and branch resolution for the memory/writeback side. Contains HI/LO registers and an iterative multiply/divide unit (MDU) that stalls upstream stages while busy.

Parameters:
DATA_WIDTH, 32, operand/result width; MDU runs DATA_WIDTH iterations.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
enable_execute  in  1  instruction valid; accepted on a rising edge only when stall=0
pc  in  32  PC of the presented instruction
opcode  in  6  insn[31:26]
func  in  6  insn[5:0]
rt  in  5  insn[20:16]
rd  in  5  insn[15:11]
sa  in  5  insn[10:6]
imm  in  26  insn[25:0]; I-type uses imm[15:0]
rs_val  in  32  value of GPR rs
rt_val  in  32  value of GPR rt
valid_out  out  1  one-cycle pulse per accepted instruction
result  out  32  ALU result / effective address / link value
dest_reg  out  5  writeback register
reg_write  out  1  writeback enable
is_load  out  1  LW
is_store  out  1  SW
store_data  out  32  rt_val registered for SW
branch_taken  out  1  redirect fetch
branch_target  out  32  redirect address
stall  out  1  MDU busy; upstream holds its outputs

Behaviour:
- Reset (async, any state incl. mid-MDU): all outputs 0, HI=LO=0, FSM=IDLE, iteration counter=0.
- Latency: non-MDU instruction accepted at edge N -> outputs valid after edge N, valid_out high for exactly one cycle; with no accept, valid_out/reg_write/is_load/is_store/branch_taken all 0.
- R-type (opcode 0), dest=rd: ADD 0x20/ADDU 0x21 (wrap, no overflow trap), SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A (signed), SLTU 0x2B, SLL 0x00/SRL 0x02/SRA 0x03 by sa on rt_val, MFHI 0x10, MFLO 0x12, JR 0x08 (target=rs_val, taken=1, no write), MULT 0x18/MULTU 0x19/DIV 0x1A/DIVU 0x1B (no GPR write).
- I-type, dest=rt: ADDIU 0x09 (sext), SLTI 0x0A, ANDI 0x0C/ORI 0x0D (zext), LUI 0x0F ({imm16,16'h0}), LW 0x23 (result=rs_val+sext, is_load, reg_write), SW 0x2B (result=address, is_store, store_data=rt_val, no write).
- BEQ 0x04/BNE 0x05: target=pc+4+(sext(imm16)<<2); taken per rs_val==rt_val compare.
- J 0x02 / JAL 0x03: target={pc+4[31:28],imm,2'b00}, taken=1; JAL writes pc+8 to r31.
- dest_reg=0 forces reg_write=0. Unknown opcode/func: NOP (valid_out=1, all else 0).
- MDU FSM IDLE -> BUSY -> FIX -> IDLE. Accept at edge 0 loads magnitudes, enters BUSY; one shift-add (mult) or restoring shift-subtract (div) step per edge; after 32 steps (edge 32) enter FIX; edge 33 applies signs, writes HI/LO, returns IDLE. stall = (state != IDLE), combinational; next instruction accepted earliest at edge 34 and sees new HI/LO.
- Signed div: quotient truncates toward zero, remainder takes dividend's sign. Divide by zero: LO=32'hFFFFFFFF, HI=dividend, same 34-cycle timing.
- enable_execute ignored while stall=1.

Optional Feature:
EXECUTE_MDU_EN -- defined: MDU, HI/LO and stall behave as above. Undefined: no MDU logic; MULT*/DIV* execute as NOP, MFHI/MFLO return 0, stall tied 0.

Test Plan:
- ADDU rs_val=0x7FFFFFFF rt_val=1 rd=3 -> next cycle result=0x80000000, dest_reg=3, reg_write=1, valid_out 1 cycle.
- SLT rs_val=0xFFFFFFFF rt_val=1 -> result=1; SLTU same operands -> result=0.
- BEQ pc=0x80020000 equal operands imm16=0xFFFF -> branch_taken=1, branch_target=0x80020000; unequal -> taken=0.
- MULT 0xFFFFFFFD x 5 then MFLO/MFHI -> stall high 33 cycles, LO=0xFFFFFFF1, HI=0xFFFFFFFF; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=7, stall timing unchanged.
- reset_n low mid-MULT (iteration 10) -> stall=0 and all outputs 0 immediately, HI=LO=0; ADDU accepted on first edge after release.
